// File: rtl/register_bank.sv
// register_bank
//   General-purpose register bank with one write port and two registered
//   read ports. Writes either load a value or add it to the stored value
//   (accumulate), which produces a carry. A write and a read of the same
//   address in one cycle bypass the new value straight to the read port.
//   Each register has a valid bit. A single-cycle bulk clear is provided.
//   Register 0 can optionally be hardwired to zero.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   reset      in   asynchronous active-high reset of all state and outputs
//   clr        in   synchronous bulk clear; discards a write in the same cycle
//   wr_en      in   write request
//   wr_mode    in   0 = load, 1 = accumulate
//   wr_addr    in   write target register
//   wr_data    in   write operand
//   rd_addr_a  in   read port A address
//   rd_addr_b  in   read port B address
//   rd_data_a  out  registered read data, port A
//   rd_data_b  out  registered read data, port B
//   rd_valid_a out  registered valid bit, port A
//   rd_valid_b out  registered valid bit, port B
//   carry      out  carry out of the last accepted write
module register_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic                  wr_mode,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_valid_a,
  output logic                  rd_valid_b,
  output logic                  carry
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic                  carry_q;
  logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_b_q;
  logic                  rd_valid_a_q, rd_valid_b_q;

  logic                  wr_accept_s;
  logic [DATA_WIDTH:0]   sum_s;
  logic [DATA_WIDTH-1:0] wr_value_s;
  logic                  wr_carry_s;
  logic [DATA_WIDTH:0]   rd_a_d, rd_b_d;   // {valid, data}

  // Next read-port contents: clear wins, then the hardwired zero register,
  // then bypass of this cycle's write, then the stored register.
  function automatic logic [DATA_WIDTH:0] read_next(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  clr_i,
    input logic                  accept_i,
    input logic [ADDR_WIDTH-1:0] waddr_i,
    input logic [DATA_WIDTH-1:0] wvalue_i,
    input logic [DATA_WIDTH-1:0] stored_i,
    input logic                  stored_valid_i
  );
    logic [DATA_WIDTH:0] r;
    if (clr_i) begin
      r = '0;
    end else if ((ZERO_REG != 0) && (addr == '0)) begin
      r = {1'b1, {DATA_WIDTH{1'b0}}};
    end else if (accept_i && (waddr_i == addr)) begin
      r = {1'b1, wvalue_i};
    end else begin
      r = {stored_valid_i, stored_i};
    end
    return r;
  endfunction

  // Write acceptance, write value and carry, and next read-port values.
  always_comb begin
    wr_accept_s = wr_en && !clr && !((ZERO_REG != 0) && (wr_addr == '0));
    // Extra MSB of the sum is the accumulate carry-out.
    sum_s = {1'b0, regs_q[wr_addr]} + {1'b0, wr_data};
    if (wr_mode) begin
      wr_value_s = sum_s[DATA_WIDTH-1:0];
      wr_carry_s = sum_s[DATA_WIDTH];
    end else begin
      wr_value_s = wr_data;
      wr_carry_s = 1'b0;
    end
    rd_a_d = read_next(rd_addr_a, clr, wr_accept_s, wr_addr, wr_value_s,
                       regs_q[rd_addr_a], valid_q[rd_addr_a]);
    rd_b_d = read_next(rd_addr_b, clr, wr_accept_s, wr_addr, wr_value_s,
                       regs_q[rd_addr_b], valid_q[rd_addr_b]);
  end

  // Register storage, valid bits, carry flag and registered read ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      valid_q      <= '0;
      carry_q      <= 1'b0;
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
    end else begin
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) begin
          regs_q[i] <= '0;
        end
        valid_q <= '0;
        carry_q <= 1'b0;
      end else if (wr_accept_s) begin
        regs_q[wr_addr]  <= wr_value_s;
        valid_q[wr_addr] <= 1'b1;
        carry_q          <= wr_carry_s;
      end else begin
        carry_q <= carry_q;
      end
      rd_data_a_q  <= rd_a_d[DATA_WIDTH-1:0];
      rd_valid_a_q <= rd_a_d[DATA_WIDTH];
      rd_data_b_q  <= rd_b_d[DATA_WIDTH-1:0];
      rd_valid_b_q <= rd_b_d[DATA_WIDTH];
    end
  end

  assign rd_data_a  = rd_data_a_q;
  assign rd_data_b  = rd_data_b_q;
  assign rd_valid_a = rd_valid_a_q;
  assign rd_valid_b = rd_valid_b_q;
  assign carry      = carry_q;

endmodule
